// File: rtl/i2c_slave_regfile.sv
// I2C target with an internal byte register file: oversampled SCL/SDA, START/STOP
// detection, pointer auto-increment on burst writes and reads, open-drain SDA enable.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1001011,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00,
  localparam int        PTR_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SCL_i,
  input  logic             SDA_i,
  output logic             SDA_oe_o,
  output logic             add_Ack_o,
  output logic             reg_Ack_o,
  output logic             data_Ack_o,
  output logic             wr_valid_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             busy_o,
  input  logic [PTR_W-1:0] host_rd_addr_i,
  output logic [7:0]       host_rd_data_o
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             sr_q, sr_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d, ptr_inc_s;
  logic                   oe_q, oe_d, busy_q, busy_d;
  logic                   add_ack_q, add_ack_d, reg_ack_q, reg_ack_d, data_ack_q, data_ack_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic [7:0]             regs_q [NUM_REGS];
  logic [7:0]             byte_in_s, rd_byte_s;
  logic                   addr_hit_s, ptr_ok_s;

  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL_i};
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA_i};
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_q;
  assign scl_fall_s = ~scl_s & scl_prev_q;
  assign start_s    = scl_s & sda_prev_q & ~sda_s;
  assign stop_s     = scl_s & ~sda_prev_q & sda_s;

  assign byte_in_s  = {sr_q[6:0], sda_s};
  assign rd_byte_s  = regs_q[ptr_q];
  assign addr_hit_s = (byte_in_s[7:1] == SLAVE_ADDR) && (byte_in_s[7:1] != 7'd0);
  assign ptr_ok_s   = ({24'd0, byte_in_s} < 32'(NUM_REGS));
  assign ptr_inc_s  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? {PTR_W{1'b0}} : ptr_q + PTR_W'(1);

  assign host_rd_data_o = ({{(32-PTR_W){1'b0}}, host_rd_addr_i} < 32'(NUM_REGS))
                          ? regs_q[host_rd_addr_i] : RESET_VAL;

  assign SDA_oe_o   = oe_q;
  assign add_Ack_o  = add_ack_q;
  assign reg_Ack_o  = reg_ack_q;
  assign data_Ack_o = data_ack_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;

  // Protocol engine: START/STOP override bit handling; ACK slots use cnt 8 -> 0 as phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    add_ack_d  = 1'b0;
    reg_ack_d  = 1'b0;
    data_ack_d = 1'b0;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (stop_s) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_s) begin
      state_d = ST_ADDR;
      cnt_d   = 4'd0;
      sr_d    = 8'h00;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_s) begin
            sr_d  = byte_in_s;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q != 4'd7) begin
              state_d = state_q;
            end else if (state_q == ST_ADDR) begin
              if (addr_hit_s) begin
                state_d   = ST_ADDR_ACK;
                add_ack_d = 1'b1;
                busy_d    = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else if (state_q == ST_PTR) begin
              if (ptr_ok_s) begin
                state_d   = ST_PTR_ACK;
                ptr_d     = byte_in_s[PTR_W-1:0];
                reg_ack_d = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else begin
              state_d    = ST_WDATA_ACK;
              wr_valid_d = 1'b1;
              data_ack_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_in_s;
              ptr_d      = ptr_inc_s;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s && cnt_q == 4'd8) begin
            oe_d = 1'b1;
          end else if (scl_rise_s) begin
            cnt_d = 4'd0;
          end else if (scl_fall_s && cnt_q == 4'd0) begin
            oe_d = 1'b0;
            if (state_q == ST_ADDR_ACK && sr_q[0]) begin
              state_d = ST_RDATA;
              sr_d    = rd_byte_s;
              oe_d    = ~rd_byte_s[7];
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WDATA;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_RDATA: begin
          if (scl_rise_s) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall_s && cnt_q == 4'd8) begin
            oe_d    = 1'b0;
            state_d = ST_RDATA_ACK;
          end else if (scl_fall_s && cnt_q != 4'd0) begin
            sr_d = {sr_q[6:0], 1'b0};
            oe_d = ~sr_q[6];
          end else begin
            state_d = state_q;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise_s && !sda_s) begin
            ptr_d = ptr_inc_s;
            cnt_d = 4'd0;
          end else if (scl_rise_s) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall_s && cnt_q == 4'd0) begin
            state_d = ST_RDATA;
            sr_d    = rd_byte_s;
            oe_d    = ~rd_byte_s[7];
          end else begin
            state_d = state_q;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // Synchronisers, edge history, FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      sr_q       <= 8'h00;
      ptr_q      <= {PTR_W{1'b0}};
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      add_ack_q  <= 1'b0;
      reg_ack_q  <= 1'b0;
      data_ack_q <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= {PTR_W{1'b0}};
      wr_data_q  <= 8'h00;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      add_ack_q  <= add_ack_d;
      reg_ack_q  <= reg_ack_d;
      data_ack_q <= data_ack_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Register file commits the byte announced on the write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (wr_valid_q) begin
      regs_q[wr_addr_q] <= wr_data_q;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-level I2C master, wired-AND SDA, and a
// transaction-level register/pointer model checked against the bus and host port.
module tb_i2c_slave_regfile;
  localparam logic [6:0] SLV  = 7'b1001011;
  localparam int         NREG = 16;
  localparam int         PW   = 4;
  localparam int         Q    = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_line;
  logic          SDA_oe_o, add_Ack_o, reg_Ack_o, data_Ack_o, wr_valid_o, busy_o;
  logic [PW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o, host_rd_data_o;
  logic [PW-1:0] host_rd_addr = '0;

  int            n_chk = 0, n_err = 0;
  int            n_add = 0, n_reg = 0, n_data = 0;
  logic [11:0]   wr_log[$];
  logic [11:0]   exp_log[$];
  logic [7:0]    tx_q[$];
  logic [7:0]    m_regs[NREG];
  int            m_ptr = 0;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~SDA_oe_o;

  i2c_slave_regfile #(.SLAVE_ADDR(SLV), .NUM_REGS(NREG), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .SCL_i(scl_m), .SDA_i(sda_line), .SDA_oe_o(SDA_oe_o),
    .add_Ack_o(add_Ack_o), .reg_Ack_o(reg_Ack_o), .data_Ack_o(data_Ack_o),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o),
    .host_rd_addr_i(host_rd_addr), .host_rd_data_o(host_rd_data_o)
  );

  always @(negedge clk) begin
    if (add_Ack_o) n_add++;
    if (reg_Ack_o) n_reg++;
    if (data_Ack_o) n_data++;
    if (wr_valid_o) wr_log.push_back({wr_addr_o, wr_data_o});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b;   idle(Q);
    scl_m = 1'b1; idle(Q);
    s = sda_line; idle(Q);
    scl_m = 1'b0; idle(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(~mack, s);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; idle(Q);
    scl_m = 1'b1; idle(Q);
    sda_m = 1'b0; idle(Q);
    scl_m = 1'b0; idle(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; idle(Q);
    scl_m = 1'b1; idle(Q);
    sda_m = 1'b1; idle(2 * Q);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic check_host();
    for (int i = 0; i < NREG; i++) begin
      host_rd_addr = PW'(i);
      #1;
      chk("host_rd", 32'(host_rd_data_o), 32'(m_regs[i]));
    end
  endtask

  // Write transaction of tx_q bytes; acks and writes predicted from address/pointer rules.
  task automatic txn_write(input logic [6:0] addr7, input logic [7:0] ptr_b);
    logic ack;
    int hit, pok, a0, r0, d0;
    hit = (addr7 == SLV) ? 1 : 0;
    pok = (hit == 1 && int'(ptr_b) < NREG) ? 1 : 0;
    a0 = n_add; r0 = n_reg; d0 = n_data;
    wr_log.delete();
    exp_log.delete();
    i2c_start();
    write_byte({addr7, 1'b0}, ack);
    chk("wr_addr_ack", 32'(ack), 32'(hit));
    write_byte(ptr_b, ack);
    chk("wr_ptr_ack", 32'(ack), 32'(pok));
    if (pok == 1) m_ptr = int'(ptr_b);
    foreach (tx_q[i]) begin
      write_byte(tx_q[i], ack);
      chk("wr_data_ack", 32'(ack), 32'(pok));
      if (pok == 1) begin
        exp_log.push_back({PW'(m_ptr), tx_q[i]});
        m_regs[m_ptr] = tx_q[i];
        m_ptr = (m_ptr + 1) % NREG;
      end
    end
    i2c_stop();
    chk("busy_after_stop", 32'(busy_o), 32'd0);
    chk("add_pulses", 32'(n_add - a0), 32'(hit));
    chk("reg_pulses", 32'(n_reg - r0), 32'(pok));
    chk("data_pulses", 32'(n_data - d0), (pok == 1) ? 32'(tx_q.size()) : 32'd0);
    chk("wr_count", 32'(wr_log.size()), 32'(exp_log.size()));
    foreach (exp_log[i]) if (i < wr_log.size()) chk("wr_entry", 32'(wr_log[i]), 32'(exp_log[i]));
  endtask

  // Optional pointer set, then (repeated) START read of n bytes, last one NACKed.
  task automatic txn_read(input int set_ptr, input int ptr, input int n);
    logic ack;
    logic [7:0] b;
    if (set_ptr != 0) begin
      i2c_start();
      write_byte({SLV, 1'b0}, ack);
      chk("rd_waddr_ack", 32'(ack), 32'd1);
      write_byte(8'(ptr), ack);
      chk("rd_ptr_ack", 32'(ack), 32'd1);
      m_ptr = ptr;
    end
    i2c_start();
    write_byte({SLV, 1'b1}, ack);
    chk("rd_addr_ack", 32'(ack), 32'd1);
    chk("busy_in_read", 32'(busy_o), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, (i < n - 1));
      chk("rd_data", 32'(b), 32'(m_regs[m_ptr]));
      if (i < n - 1) m_ptr = (m_ptr + 1) % NREG;
    end
    read_byte(b, 1'b0);
    chk("rd_released", 32'(b), 32'hFF);
    i2c_stop();
    chk("busy_after_read", 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic ack, s;
    logic [7:0] b;
    logic [6:0] ra;
    model_reset();
    idle(5);
    chk("rst_oe", 32'(SDA_oe_o), 32'd0);
    chk("rst_pulses", 32'({add_Ack_o, reg_Ack_o, data_Ack_o, wr_valid_o}), 32'd0);
    chk("rst_wr_bus", 32'({wr_addr_o, wr_data_o}), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;
    idle(10);
    check_host();

    tx_q = '{8'hA5};
    txn_write(SLV, 8'h03);
    host_rd_addr = 4'd3; #1;
    chk("host_rd3_a5", 32'(host_rd_data_o), 32'hA5);

    tx_q = '{8'h11, 8'h22, 8'h33};
    txn_write(SLV, 8'h0E);
    txn_read(1, 14, 2);

    tx_q = '{8'h5A, 8'hC3};
    txn_write(7'h4A, 8'h01);
    tx_q = '{8'h77, 8'h88};
    txn_write(SLV, 8'h10);
    check_host();

    // STOP after 4 data bits: partial byte must be dropped.
    wr_log.delete();
    i2c_start();
    write_byte({SLV, 1'b0}, ack);
    write_byte(8'h03, ack);
    m_ptr = 3;
    for (int i = 0; i < 4; i++) send_bit(1'b0, s);
    i2c_stop();
    chk("abort_no_write", 32'(wr_log.size()), 32'd0);
    check_host();

    // Reset while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      b = {SLV, 1'b0};
      send_bit(b[i], s);
    end
    chk("ack_driven", 32'(SDA_oe_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("oe_on_reset", 32'(SDA_oe_o), 32'd0);
    chk("busy_on_reset", 32'(busy_o), 32'd0);
    sda_m = 1'b1; idle(2);
    scl_m = 1'b1; idle(4);
    reset = 1'b0;
    model_reset();
    idle(10);
    check_host();

    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          tx_q.delete();
          repeat ($urandom_range(1, 4)) tx_q.push_back(8'($urandom));
          txn_write(SLV, 8'($urandom_range(0, 19)));
        end
        1: txn_read(1, $urandom_range(0, NREG - 1), $urandom_range(1, 3));
        2: txn_read(0, 0, $urandom_range(1, 3));
        default: begin
          ra = 7'($urandom_range(0, 127));
          if (ra == SLV) ra = ra ^ 7'd1;
          tx_q = '{8'($urandom)};
          txn_write(ra, 8'($urandom_range(0, 15)));
        end
      endcase
    end
    check_host();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
